bloco_controle: RTL and testbench
=================================

Name: bloco_controle

Overview:
- Control FSM for the traffic-light (semaphore) design; drives the load/clear inputs of the operational block's 7 s / 5 s / 0.5 s timers and consumes their fim_* flags.
- Generates car and pedestrian light outputs and latches the pedestrian request button.
- Instantiated alongside the datapath in the semaphore top level; datapath counters advance at one tick per clock (0.25 s per tick).

Parameters:
- AUTO_CYCLE, 0, 1 = leave car-green on fim_7s alone; 0 = car-green also requires a latched pedestrian request.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- botao  input  1  pedestrian request button, synchronous level, any pulse width ≥ 1 cycle
- fim_7s  input  1  7 s timer expired (from datapath)
- fim_5s  input  1  5 s timer expired (from datapath)
- fim_05s  input  1  0.5 s timer expired (from datapath)
- load_Reg7s / clear_Reg7s  output  1 each  7 s timer count enable / clear
- load_Reg5s / clear_Reg5s  output  1 each  5 s timer count enable / clear
- load_Reg05s / clear_Reg05s  output  1 each  0.5 s timer count enable / clear
- carro_verde, carro_amarelo, carro_vermelho  output  1 each  car lights, one-hot
- pedestre_verde, pedestre_vermelho  output  1 each  pedestrian lights, one-hot
- pedido  output  1  latched pedestrian request
- estado  output  2  current state encoding, for debug

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high on rst.
- Reset: on the rst edge, state = INIT and pedido = 0; rst has priority over everything.
- States: INIT=0, VERDE=1, AMARELO=2, VERMELHO=3.
- All outputs are Moore, decoded from the registered state and pedido. No combinational path from fim_* or botao to any output.
- INIT:
  - All clear_* = 1, all load_* = 0.
  - carro_vermelho = 1, pedestre_vermelho = 1.
  - Unconditional transition to VERDE on the next edge.
- VERDE:
  - load_Reg7s = 1, clear_Reg5s = 1, clear_Reg05s = 1.
  - carro_verde = 1, pedestre_vermelho = 1.
  - Exit to AMARELO when fim_7s && (pedido || AUTO_CYCLE).
- AMARELO:
  - load_Reg05s = 1, clear_Reg7s = 1, clear_Reg5s = 1.
  - carro_amarelo = 1, pedestre_vermelho = 1.
  - Exit to VERMELHO when fim_05s.
- VERMELHO:
  - load_Reg5s = 1, clear_Reg7s = 1, clear_Reg05s = 1.
  - carro_vermelho = 1, pedestre_verde = 1.
  - Exit to VERDE when fim_5s.
- Timer handling:
  - Every timer not owned by the current state is held cleared, so each timed state starts with its counter at 0.
  - load and clear are never both 1 for the same timer.
- pedido register:
  - Set when botao = 1 in INIT, VERDE or AMARELO.
  - Cleared on the edge that enters VERMELHO; clearing wins over a simultaneous botao.
  - botao is ignored during VERMELHO.
  - Multiple presses collapse into one request.
- Latency: a state transition happens on the first edge where its condition is sampled true, i.e. 1 cycle after the flag rises.
- Dwell times with datapath counts 7s=27, 5s=19, 05s=1:
  - VERDE ≥ 28 cycles.
  - AMARELO = 2 cycles.
  - VERMELHO = 20 cycles.
- fim_7s already high with no request: stay in VERDE indefinitely (AUTO_CYCLE=0). Leave on the edge after pedido becomes 1.
- botao pressed in the same cycle that fim_7s first rises: pedido sets on that edge; the exit follows one edge later.
- Illegal or unreachable encoding: go to INIT.
- Exactly one car light and exactly one pedestrian light are high in every cycle, including INIT.

Decomposition:
- Shared package semaforo_pkg holds:
  - state encoding constants (S_INIT, S_VERDE, S_AMARELO, S_VERMELHO, 2-bit);
  - timer count constants 27/19/1, also used by the datapath.
- No sub-module: the FSM plus the pedido flop are one block.
- The top level (semaforo_top) wires this block to the datapath.

Test Plan:
- Reset, then hold botao=0 for 200 cycles with a real-count datapath model → INIT for 1 cycle, then VERDE held throughout; carro_verde=1, pedestre_vermelho=1, pedido=0.
- Pulse botao for 1 cycle at cycle 5 after reset → VERDE exits at cycle 29 after entry; AMARELO lasts 2 cycles; VERMELHO lasts 20 cycles with pedestre_verde=1; pedido=0 on entering VERMELHO; back to VERDE.
- Press botao at cycle 100 in VERDE (fim_7s already high) → pedido=1 at 101, AMARELO at 102.
- Hold botao high through a whole VERMELHO → pedido stays 0 throughout VERMELHO; pedido sets on the first VERDE cycle; a second cycle follows after 28 cycles.
- Assert rst for 1 cycle mid-VERMELHO → INIT next cycle with all clear_*=1 and pedido=0; VERDE follows, with the 7 s timer starting from 0.
- AUTO_CYCLE=1, botao=0 → continuous cycle VERDE 28 / AMARELO 2 / VERMELHO 20 cycles. Every cycle: light one-hot check; load/clear of the same timer never both 1.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light controller and its datapath.
// State encoding and timer terminal counts (one tick = 0.25 s).
package semaforo_pkg;

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_VERDE    = 2'd1,
    S_AMARELO  = 2'd2,
    S_VERMELHO = 2'd3
  } estado_t;

  localparam int CNT_7S  = 27;
  localparam int CNT_5S  = 19;
  localparam int CNT_05S = 1;

endpackage

// File: rtl/bloco_controle.sv
// Traffic-light control FSM: sequences the car/pedestrian lights,
// drives the datapath timers and latches the pedestrian request.
module bloco_controle
  import semaforo_pkg::*;
#(
  parameter bit AUTO_CYCLE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       botao,
  input  logic       fim_7s,
  input  logic       fim_5s,
  input  logic       fim_05s,
  output logic       load_Reg7s,
  output logic       clear_Reg7s,
  output logic       load_Reg5s,
  output logic       clear_Reg5s,
  output logic       load_Reg05s,
  output logic       clear_Reg05s,
  output logic       carro_verde,
  output logic       carro_amarelo,
  output logic       carro_vermelho,
  output logic       pedestre_verde,
  output logic       pedestre_vermelho,
  output logic       pedido,
  output logic [1:0] estado
);

  estado_t st;
  logic    entra_vermelho;

  assign entra_vermelho = (st == S_AMARELO) && fim_05s;

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= S_INIT;
      pedido <= 1'b0;
    end else begin
      case (st)
        S_INIT:     st <= S_VERDE;
        S_VERDE:
          if (fim_7s && (pedido || AUTO_CYCLE))
            st <= S_AMARELO;
        S_AMARELO:
          if (fim_05s) st <= S_VERMELHO;
        S_VERMELHO:
          if (fim_5s) st <= S_VERDE;
        default:    st <= S_INIT;
      endcase
      // the request is served by the red phase, so clearing wins
      if (entra_vermelho)
        pedido <= 1'b0;
      else if (botao && st != S_VERMELHO)
        pedido <= 1'b1;
    end
  end

  assign estado = st;

  always_comb begin
    load_Reg7s        = 1'b0;
    clear_Reg7s       = 1'b1;
    load_Reg5s        = 1'b0;
    clear_Reg5s       = 1'b1;
    load_Reg05s       = 1'b0;
    clear_Reg05s      = 1'b1;
    carro_verde       = 1'b0;
    carro_amarelo     = 1'b0;
    carro_vermelho    = 1'b1;
    pedestre_verde    = 1'b0;
    pedestre_vermelho = 1'b1;
    unique case (st)
      S_VERDE: begin
        load_Reg7s     = 1'b1;
        clear_Reg7s    = 1'b0;
        carro_verde    = 1'b1;
        carro_vermelho = 1'b0;
      end
      S_AMARELO: begin
        load_Reg05s    = 1'b1;
        clear_Reg05s   = 1'b0;
        carro_amarelo  = 1'b1;
        carro_vermelho = 1'b0;
      end
      S_VERMELHO: begin
        load_Reg5s        = 1'b1;
        clear_Reg5s       = 1'b0;
        pedestre_verde    = 1'b1;
        pedestre_vermelho = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bloco_controle.sv
// Bench for bloco_controle: two instances (request-driven and auto-cycle)
// each closed around a counting datapath, checked against a dwell-time model.
module tb_bloco_controle;
  import semaforo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic botao = 1'b0;
  logic [1:0] f7, f5, f05;
  logic [1:0] ld7, cl7, ld5, cl5, ld05, cl05;
  logic [1:0] cv, ca, cr, pv, pr, ped;
  logic [1:0] est [2];

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  bloco_controle #(.AUTO_CYCLE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .botao(botao),
    .fim_7s(f7[0]), .fim_5s(f5[0]), .fim_05s(f05[0]),
    .load_Reg7s(ld7[0]), .clear_Reg7s(cl7[0]),
    .load_Reg5s(ld5[0]), .clear_Reg5s(cl5[0]),
    .load_Reg05s(ld05[0]), .clear_Reg05s(cl05[0]),
    .carro_verde(cv[0]), .carro_amarelo(ca[0]),
    .carro_vermelho(cr[0]), .pedestre_verde(pv[0]),
    .pedestre_vermelho(pr[0]), .pedido(ped[0]), .estado(est[0])
  );

  bloco_controle #(.AUTO_CYCLE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .botao(botao),
    .fim_7s(f7[1]), .fim_5s(f5[1]), .fim_05s(f05[1]),
    .load_Reg7s(ld7[1]), .clear_Reg7s(cl7[1]),
    .load_Reg5s(ld5[1]), .clear_Reg5s(cl5[1]),
    .load_Reg05s(ld05[1]), .clear_Reg05s(cl05[1]),
    .carro_verde(cv[1]), .carro_amarelo(ca[1]),
    .carro_vermelho(cr[1]), .pedestre_verde(pv[1]),
    .pedestre_vermelho(pr[1]), .pedido(ped[1]), .estado(est[1])
  );

  // datapath: saturating counters, clear has priority
  int c7 [2];
  int c5 [2];
  int c05 [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || cl7[i]) c7[i] <= 0;
      else if (ld7[i] && c7[i] < CNT_7S) c7[i] <= c7[i] + 1;
      if (rst || cl5[i]) c5[i] <= 0;
      else if (ld5[i] && c5[i] < CNT_5S) c5[i] <= c5[i] + 1;
      if (rst || cl05[i]) c05[i] <= 0;
      else if (ld05[i] && c05[i] < CNT_05S) c05[i] <= c05[i] + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      f7[i]  = (c7[i] >= CNT_7S);
      f5[i]  = (c5[i] >= CNT_5S);
      f05[i] = (c05[i] >= CNT_05S);
    end
  end

  // reference: phase + cycles spent in phase, request flag
  int m_ph [2];
  int m_t  [2];
  bit m_ped [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int nx;
      nx = m_ph[i];
      if (rst) begin
        m_ph[i]  <= 0;
        m_t[i]   <= 0;
        m_ped[i] <= 1'b0;
      end else begin
        if (m_ph[i] == 0) nx = 1;
        else if (m_ph[i] == 1) begin
          if (m_t[i] >= 27 && (m_ped[i] || i == 1)) nx = 2;
        end else if (m_ph[i] == 2) begin
          if (m_t[i] >= 1) nx = 3;
        end else if (m_t[i] >= 19) nx = 1;
        m_ph[i] <= nx;
        m_t[i]  <= (nx == m_ph[i]) ? m_t[i] + 1 : 0;
        if (nx == 3 && m_ph[i] != 3) m_ped[i] <= 1'b0;
        else if (botao && m_ph[i] != 3) m_ped[i] <= 1'b1;
      end
    end
  end

  // {ld7,cl7,ld5,cl5,ld05,cl05,cv,ca,cr,pv,pr}
  function automatic logic [10:0] exp_out(int ph);
    case (ph)
      1: return 11'b10_01_01_100_01;
      2: return 11'b01_01_10_010_01;
      3: return 11'b01_10_01_001_10;
      default: return 11'b01_01_01_001_01;
    endcase
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  int pst [2] = '{-1, -1};
  int run [2] = '{0, 0};
  bit dv  [2] = '{0, 0};

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        logic [10:0] act;
        act = {ld7[i], cl7[i], ld5[i], cl5[i], ld05[i], cl05[i],
               cv[i], ca[i], cr[i], pv[i], pr[i]};
        chk("outputs", i, 32'(act), 32'(exp_out(m_ph[i])));
        chk("estado", i, 32'(est[i]), 32'(m_ph[i]));
        chk("pedido", i, 32'(ped[i]), 32'(m_ped[i]));
        chk("car_onehot", i, $countones({cv[i], ca[i], cr[i]}), 1);
        chk("ped_onehot", i, $countones({pv[i], pr[i]}), 1);
        chk("load_clear", i,
            32'((ld7[i] & cl7[i]) | (ld5[i] & cl5[i]) | (ld05[i] & cl05[i])), 0);
        if (32'(est[i]) != pst[i]) begin
          if (dv[i]) begin
            if (pst[i] == 0) chk("dwell_init", i, run[i], 1);
            if (pst[i] == 1 && i == 1) chk("dwell_verde", i, run[i], 28);
            if (pst[i] == 1 && i == 0) chk("dwell_verde_min", i, 32'(run[i] >= 28), 1);
            if (pst[i] == 2) chk("dwell_amarelo", i, run[i], 2);
            if (pst[i] == 3) chk("dwell_vermelho", i, run[i], 20);
          end
          pst[i] = 32'(est[i]);
          run[i] = 1;
          dv[i]  = 1'b1;
        end else run[i]++;
        if (rst) dv[i] = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int mode;

  initial begin
    step();
    started = 1'b1;
    rst = 1'b0;
    #2;
    chk("reset_estado", 0, 32'(est[0]), 0);
    chk("reset_clears", 0, 32'({cl7[0], cl5[0], cl05[0], ld7[0], ld5[0], ld05[0]}), 32'b111000);
    chk("reset_pedido", 0, 32'(ped[0]), 0);
    repeat (100) step();
    #2;
    chk("verde_hold", 0, 32'({est[0], ped[0], cv[0], pr[0], f7[0]}), 32'b01_0_1_1_1);
    botao = 1'b1;
    step();
    botao = 1'b0;
    #2;
    chk("press_pedido", 0, 32'({est[0], ped[0]}), 32'b01_1);
    step();
    #2;
    chk("press_amarelo", 0, 32'(est[0]), 2);
    step();
    step();
    #2;
    chk("vermelho_entry", 0, 32'({est[0], ped[0], pv[0]}), 32'b11_0_1);
    for (int blk = 0; blk < 16; blk++) begin
      mode = int'($urandom_range(0, 2));
      for (int c = 0; c < 250; c++) begin
        if (mode == 0) botao = 1'b0;
        else if (mode == 1) botao = ($urandom_range(0, 39) == 0);
        else botao = 1'b1;
        rst = ($urandom_range(0, 599) == 0);
        step();
      end
    end
    rst = 1'b0;
    botao = 1'b0;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
